// File: rtl/ps2_rx.sv
// ps2_rx -- PS/2 device-to-host frame receiver.
//
// Receives 11-bit PS/2 frames: start (0), 8 data bits LSB first, odd parity,
// and stop (1). Data is sampled on the falling edge of a glitch-filtered
// copy of the PS/2 clock. rx_en_i is held low while the host-side
// transmitter owns the bus. Any frame in progress is dropped without a
// pulse when rx_en_i goes low.
//
// Ports:
//   clk_i         system clock
//   reset_i       asynchronous, active-high reset
//   rx_en_i       receive enable; low = ignore bus / abort frame
//   ps2c_i        PS/2 clock line (asynchronous)
//   ps2d_i        PS/2 data line (asynchronous)
//   rx_data_o     last good byte, held until the next good frame
//   rx_done_o     1-cycle pulse: frame received with a valid stop bit
//   parity_err_o  1-cycle pulse alongside rx_done_o when parity is not odd
//   frame_err_o   1-cycle pulse: bad stop bit or inter-edge timeout
//   idle_o        high while the receiver is in IDLE
//
// Output pulse protocol: rx_done_o, parity_err_o and frame_err_o are
// single-cycle strobes with no back-pressure. rx_data_o is valid from the
// cycle where rx_done_o is high until the next rx_done_o pulse.
// Each frame produces at most one strobe cycle.

module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_en_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // Input conditioning
    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_q;
    logic                  filt_next;
    logic                  ps2d_s;
    logic                  fall;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            c_sync  <= 2'b11;
            d_sync  <= 2'b11;
            filt_sr <= '1;
            filt_q  <= 1'b1;
        end else begin
            c_sync  <= {c_sync[0], ps2c_i};
            d_sync  <= {d_sync[0], ps2d_i};
            filt_sr <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
            filt_q  <= filt_next;
        end
    end

    // The filtered clock only changes when the whole window agrees, so
    // pulses shorter than FILTER_LEN cycles are ignored.
    always_comb begin
        filt_next = filt_q;
        if (&filt_sr) begin
            filt_next = 1'b1;
        end else if (~|filt_sr) begin
            filt_next = 1'b0;
        end
    end

    assign fall   = filt_q & ~filt_next;
    assign ps2d_s = d_sync[1];

    // Frame FSM
    state_t        state_q, state_n;
    logic [3:0]    bit_cnt_q, bit_cnt_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [8:0]    shift_q, shift_n;
    logic [7:0]    data_q, data_n;
    logic          done_q, done_n;
    logic          perr_q, perr_n;
    logic          ferr_q, ferr_n;
    logic          idle_q;
    logic          timeout;

    assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        timer_n   = timer_q;
        shift_n   = shift_q;
        data_n    = data_q;
        done_n    = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && rx_en_i && !ps2d_s) begin
                    state_n   = S_DATA;
                    bit_cnt_n = 4'd0;
                    timer_n   = '0;
                end
            end
            S_DATA, S_STOP: begin
                if (!rx_en_i) begin
                    state_n = S_IDLE;
                end else if (fall) begin
                    timer_n = '0;
                    if (state_q == S_DATA) begin
                        // Bits arrive LSB first; after nine shifts the
                        // parity bit lands in shift[8].
                        shift_n   = {ps2d_s, shift_q[8:1]};
                        bit_cnt_n = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd8) begin
                            state_n = S_STOP;
                        end
                    end else begin
                        state_n = S_IDLE;
                        if (ps2d_s) begin
                            data_n = shift_q[7:0];
                            done_n = 1'b1;
                            perr_n = ~(^shift_q);
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    ferr_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (timer_q != '1) begin
                    timer_n = timer_q + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            timer_q   <= '0;
            shift_q   <= 9'd0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            timer_q   <= timer_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            done_q    <= done_n;
            perr_q    <= perr_n;
            ferr_q    <= ferr_n;
            idle_q    <= (state_n == S_IDLE);
        end
    end

    assign rx_data_o    = data_q;
    assign rx_done_o    = done_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign idle_o       = idle_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx -- directed bench for ps2_rx.
// Frames are driven bit by bit. At each final falling edge the driver queues
// the expected strobe: its kind, data, parity flag and arrival cycle. A
// negedge compare process matches every strobe against that queue and checks
// rx_data_o against the held byte on every cycle.

module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 40;
    localparam int LAT  = 3 + FL;   // raw ps2c fall -> visible pulse, in cycles

    logic       clk = 1'b0;
    logic       reset_i;
    logic       rx_en_i;
    logic       ps2c_i;
    logic       ps2d_i;
    logic [7:0] rx_data_o;
    logic       rx_done_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       idle_o;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rx_en_i      (rx_en_i),
        .ps2c_i       (ps2c_i),
        .ps2d_i       (ps2d_i),
        .rx_data_o    (rx_data_o),
        .rx_done_o    (rx_done_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .idle_o       (idle_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_data = 8'h00;
    logic        last_perr  = 1'b0;
    // entry: {due_cycle[31:0], is_frame_err, parity_err, data[7:0]}
    logic [41:0] exp_q[$];
    logic [41:0] cur_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_o || frame_err_o || parity_err_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got done=%b perr=%b ferr=%b want none (cycle %0d)",
                         rx_done_o, parity_err_o, frame_err_o, cyc);
            end else begin
                cur_e = exp_q.pop_front();
                if (!cur_e[9]) model_data = cur_e[7:0];
                check("pulse_done", 32'(rx_done_o), 32'(!cur_e[9]));
                check("pulse_frame_err", 32'(frame_err_o), 32'(cur_e[9]));
                check("pulse_parity_err", 32'(parity_err_o), 32'(cur_e[8]));
                check("pulse_cycle", cyc, cur_e[41:10]);
                last_perr = parity_err_o;
            end
        end
        check("rx_data", 32'(rx_data_o), 32'(model_data));
    end

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit push,
                            input logic [9:0] ev, input int due_off);
        ps2d_i = b;
        if (glitch) begin
            wait_cyc(20);
            ps2c_i = 1'b0;
            wait_cyc(FL - 1);
            ps2c_i = 1'b1;
            wait_cyc(HALF - 20 - (FL - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2c_i = 1'b0;
        if (push) exp_q.push_back({32'(cyc + due_off), ev});
        wait_cyc(HALF);
        ps2c_i = 1'b1;
    endtask

    // Sends the first nbits of {stop, par, data, start}. When push_last is
    // set, the last bit's fall queues the outcome: done/parity/stop error for
    // a full frame, or a timeout frame error for a truncated one.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int nbits, input int glitch_idx, input bit push_last);
        logic [10:0] bits;
        logic [9:0]  ev;
        int          ones;
        int          off;
        bits = {stop, par, data, 1'b0};
        ones = $countones({par, data});
        if (nbits == 11) begin
            ev  = stop ? {1'b0, ((ones % 2) == 0), data} : {1'b1, 1'b0, 8'h00};
            off = LAT;
        end else begin
            ev  = {1'b1, 1'b0, 8'h00};
            off = LAT + TO;
        end
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], (i == glitch_idx), (push_last && (i == nbits - 1)), ev, off);
        end
        ps2d_i = 1'b1;
    endtask

    task automatic settle(input string name, input int n);
        wait_cyc(n);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Directed tests
    int low_seen;

    initial begin
        reset_i = 1'b1;
        rx_en_i = 1'b1;
        ps2c_i  = 1'b1;
        ps2d_i  = 1'b1;
        wait_cyc(3);
        check("reset_rx_data", 32'(rx_data_o), 32'h00);
        check("reset_idle", 32'(idle_o), 32'd1);
        check("reset_done", 32'(rx_done_o), 32'd0);
        check("reset_perr", 32'(parity_err_o), 32'd0);
        check("reset_ferr", 32'(frame_err_o), 32'd0);
        reset_i = 1'b0;
        wait_cyc(5);

        // 1: 0x1C, three ones + parity 0 -> odd, good stop
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b1);
        settle("t1_missing_pulse", LAT + 10);
        check("t1_rx_data", 32'(rx_data_o), 32'h1C);
        check("t1_parity", 32'(last_perr), 32'd0);

        // 3: 0xAA with stop bit 0 -> frame error, data held at 0x1C
        send_frame(8'hAA, 1'b1, 1'b0, 11, -1, 1'b1);
        settle("t3_missing_pulse", LAT + 10);
        check("t3_rx_data_held", 32'(rx_data_o), 32'h1C);

        // 2: 0xF0 (four ones) with parity 0 -> parity error with done
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b1);
        settle("t2_missing_pulse", LAT + 10);
        check("t2_rx_data", 32'(rx_data_o), 32'hF0);
        check("t2_parity", 32'(last_perr), 32'd1);

        // 4: clock stops after start + 5 data bits -> timeout
        send_frame(8'h3C, 1'b1, 1'b1, 6, -1, 1'b1);
        settle("t4_missing_timeout", TO + LAT + 10);
        check("t4_idle", 32'(idle_o), 32'd1);
        send_frame(8'h55, 1'b1, 1'b1, 11, -1, 1'b1);
        settle("t4_missing_pulse", LAT + 10);
        check("t4_rx_data", 32'(rx_data_o), 32'h55);

        // 5a: 3-cycle low glitch in IDLE with data low
        ps2d_i   = 1'b0;
        ps2c_i   = 1'b0;
        wait_cyc(3);
        ps2c_i   = 1'b1;
        low_seen = 0;
        repeat (30) begin
            wait_cyc(1);
            if (!idle_o) low_seen++;
        end
        ps2d_i = 1'b1;
        check("t5_glitch_idle", 32'(low_seen), 32'd0);
        settle("t5_glitch_no_pulse", 5);

        // 5b: FL-1 cycle glitch inside a frame, 0x81 (two ones, parity 1)
        send_frame(8'h81, 1'b1, 1'b1, 11, 3, 1'b1);
        settle("t5_missing_pulse", LAT + 10);
        check("t5_rx_data", 32'(rx_data_o), 32'h81);

        // 6a: rx_en_i drops after 4 bits
        send_frame(8'h1C, 1'b0, 1'b1, 4, -1, 1'b0);
        check("t6_busy", 32'(idle_o), 32'd0);
        rx_en_i = 1'b0;
        wait_cyc(1);
        check("t6_idle_next", 32'(idle_o), 32'd1);
        wait_cyc(20);
        rx_en_i = 1'b1;
        settle("t6_no_pulse", TO + 20);

        // 6b: reset mid-frame, then a clean 0x1C
        send_frame(8'hE7, 1'b1, 1'b1, 4, -1, 1'b0);
        check("t6_busy2", 32'(idle_o), 32'd0);
        reset_i    = 1'b1;
        model_data = 8'h00;
        #1;
        check("t6_reset_rx_data", 32'(rx_data_o), 32'h00);
        check("t6_reset_idle", 32'(idle_o), 32'd1);
        check("t6_reset_pulses", 32'({rx_done_o, parity_err_o, frame_err_o}), 32'd0);
        wait_cyc(3);
        reset_i = 1'b0;
        wait_cyc(5);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b1);
        settle("t6_missing_pulse", LAT + 10);
        check("t6_rx_data", 32'(rx_data_o), 32'h1C);

        wait_cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
